// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS-style controller:
// FSM states, opcode/funct fields, ALU control codes and ALU operation selects.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_IMM_EXEC  = 4'd11,
        S_IMM_WB    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        ALU_OP_NONE  = 3'd0,
        ALU_OP_ADD   = 3'd1,
        ALU_OP_SUB   = 3'd2,
        ALU_OP_FUNCT = 3'd3,
        ALU_OP_IMM   = 3'd4
    } alu_op_t;

    function automatic logic funct_legal(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLT);
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control decode: fixed ADD/SUB, R-type funct field,
// or immediate-class opcode, chosen by the FSM's ALU operation select.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_t      i_alu_op,
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output logic [3:0]   o_alu_control
);

    always_comb begin
        o_alu_control = ALU_AND;
        case (i_alu_op)
            ALU_OP_ADD: o_alu_control = ALU_ADD;
            ALU_OP_SUB: o_alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    FN_NOR:  o_alu_control = ALU_NOR;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            ALU_OP_IMM: begin
                case (i_opcode)
                    OP_ADDI: o_alu_control = ALU_ADD;
                    OP_SLTI: o_alu_control = ALU_SLT;
                    OP_ANDI: o_alu_control = ALU_AND;
                    OP_ORI:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM sequencing fetch, decode, memory,
// ALU, branch, jump and immediate instructions, with illegal-opcode detection.
//
// state     | meaning
// IDLE      | post-reset, all outputs idle
// FETCH     | read instruction, PC += 4
// DECODE    | register read, branch target precompute, dispatch
// MEM_ADDR  | effective address for lw/sw
// MEM_READ  | data memory read
// MEM_WB    | load result to rt
// MEM_WRITE | data memory write
// EXECUTE   | R-type ALU operation
// ALU_WB    | R-type result to rd
// BRANCH    | compare and conditionally take branch
// JUMP      | load jump target
// IMM_EXEC  | immediate ALU operation
// IMM_WB    | immediate result to rt
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic         ALU_zero,
    output logic [3:0]   ALU_control,
    output logic         PC_en,
    output logic         IorD,
    output logic         Mem_read,
    output logic         Mem_write,
    output logic         IR_write,
    output logic         Mem_to_reg,
    output logic         Reg_dst,
    output logic         Reg_write,
    output logic         ALU_src_A,
    output logic         Ext_zero,
    output logic         Illegal_op,
    output logic [1:0]   ALU_src_B,
    output logic [1:0]   PC_source,
    output logic [3:0]   state
);

    state_t  r_state;
    state_t  w_next;
    alu_op_t w_alu_op;
    logic    w_ext_zero_op;

    assign state         = r_state;
    assign w_ext_zero_op = (opcode == OP_ANDI) || (opcode == OP_ORI);

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_opcode      (opcode),
        .i_funct       (funct),
        .o_alu_control (ALU_control)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_alu_op   = ALU_OP_NONE;
        PC_en      = 1'b0;
        IorD       = 1'b0;
        Mem_read   = 1'b0;
        Mem_write  = 1'b0;
        IR_write   = 1'b0;
        Mem_to_reg = 1'b0;
        Reg_dst    = 1'b0;
        Reg_write  = 1'b0;
        ALU_src_A  = 1'b0;
        Ext_zero   = 1'b0;
        Illegal_op = 1'b0;
        ALU_src_B  = 2'b00;
        PC_source  = 2'b00;

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                Mem_read  = 1'b1;
                IR_write  = 1'b1;
                ALU_src_B = 2'b01;
                w_alu_op  = ALU_OP_ADD;
                PC_en     = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALU_src_B = 2'b11;
                w_alu_op  = ALU_OP_ADD;
                case (opcode)
                    OP_LW, OP_SW:    w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_IMM_EXEC;
                    OP_RTYPE: begin
                        if (funct_legal(funct)) w_next = S_EXECUTE;
                        else                    Illegal_op = 1'b1;
                    end
                    default: Illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                w_alu_op  = ALU_OP_ADD;
                w_next    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                Mem_read = 1'b1;
                IorD     = 1'b1;
                w_next   = S_MEM_WB;
            end
            S_MEM_WB: begin
                Reg_write  = 1'b1;
                Mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                Mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_EXECUTE: begin
                ALU_src_A = 1'b1;
                w_alu_op  = ALU_OP_FUNCT;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                Reg_write = 1'b1;
                Reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ALU_src_A = 1'b1;
                w_alu_op  = ALU_OP_SUB;
                PC_source = 2'b01;
                PC_en     = (opcode == OP_BNE) ? ~ALU_zero : ALU_zero;
            end
            S_JUMP: begin
                PC_source = 2'b10;
                PC_en     = 1'b1;
            end
            S_IMM_EXEC: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                w_alu_op  = ALU_OP_IMM;
                Ext_zero  = w_ext_zero_op;
                w_next    = S_IMM_WB;
            end
            S_IMM_WB: begin
                Reg_write = 1'b1;
                // opcode is held stable by the IR, so Ext_zero persists without a flop
                Ext_zero  = w_ext_zero_op;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
